// File: rtl/mac_dot_seq.sv
// mac_dot_seq: initiator for the 16-bit MAC datapath.
// Runs one dot-product job of `len` operand pairs through an external MAC:
// clears the accumulator, streams exactly `len` accepted pairs into it,
// waits one cycle for the MAC register to settle, then captures the
// accumulator as `result` with a one-cycle `done` pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   start     job request, sampled only while idle
//   len       number of operand pairs, sampled with start (0 = empty job)
//   in_valid  upstream operand pair valid
//   in_ready  pair accepted this cycle when in_valid is also high
//   in_a      operand A (two's complement)
//   in_b      operand B (two's complement)
//   mac_a     operand A to MAC (zero unless a pair is accepted)
//   mac_b     operand B to MAC (zero unless a pair is accepted)
//   mac_clr   active-high clear to MAC (also asserted during reset)
//   mac_op    registered accumulator from MAC
//   busy      job in progress
//   done      one-cycle pulse, result valid
//   result    captured accumulator, held until the next capture
module mac_dot_seq #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic             mac_clr,
    input  logic [DW-1:0]    mac_op,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    result
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [LEN_W-1:0] count;
    logic             accept;
    logic             lastAccept;

    assign accept     = in_valid & in_ready;
    assign lastAccept = accept && (count == LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (start && (len != '0)) stateNext = CLEAR;
            CLEAR: stateNext = FEED;
            FEED:  if (lastAccept) stateNext = DRAIN;
            DRAIN: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Job counter, result capture and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            count <= len;
                        end else begin
                            // Empty job completes immediately with a zero sum.
                            result <= '0;
                            done   <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (accept) count <= count - LEN_W'(1);
                end
                DRAIN: begin
                    // MAC register has absorbed the final product by now.
                    result <= mac_op;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs. mac_clr follows reset combinationally so the MAC clears with us.
    always_comb begin
        in_ready = (state == FEED);
        busy     = (state != IDLE);
        mac_clr  = ~rst | (state == CLEAR);
        mac_a    = '0;
        mac_b    = '0;
        // Stalled cycles feed zeros so the accumulator adds nothing.
        if (accept) begin
            mac_a = in_a;
            mac_b = in_b;
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed testbench for mac_dot_seq with a behavioural 16-bit MAC attached.
module tb_mac_dot_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_clr;
    logic [15:0] mac_op;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int total = 0;
    int bad   = 0;

    logic [15:0] jobA [8];
    logic [15:0] jobB [8];
    int          stallBefore [8];

    mac_dot_seq #(.LEN_W(8), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_op(mac_op),
        .busy(busy), .done(done), .result(result)
    );

    // Behavioural MAC: registered accumulator, 16-bit wrap; low 16 bits of
    // the product are identical for signed and unsigned operands.
    logic [15:0] macAcc;
    always_ff @(posedge clk) begin
        if (mac_clr) macAcc <= '0;
        else         macAcc <= macAcc + mac_a * mac_b;
    end
    assign mac_op = macAcc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_job();
        for (int i = 0; i < 8; i++) begin
            jobA[i] = '0;
            jobB[i] = '0;
            stallBefore[i] = 0;
        end
    endtask

    // Runs a job; returns cycles from start-sampling edge to the done cycle,
    // number of in_ready cycles, stall cycles with nonzero MAC operands and
    // the result seen with done. Optionally raises start in the done cycle.
    task automatic do_job(input int n, input bit preStarted, input bit chain,
                          input int nextLen, output int cyc, output int rdy,
                          output int stallBad, output logic [15:0] res);
        int idx;
        int stallLeft;
        idx = 0;
        stallLeft = stallBefore[0];
        cyc = 0;
        rdy = 0;
        stallBad = 0;
        res = 'x;
        if (!preStarted) begin
            @(negedge clk);
            start = 1'b1;
            len = 8'(n);
        end
        while (cyc < 100) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b0;
            in_a = '0;
            in_b = '0;
            cyc++;
            #1;
            if (done) begin
                res = result;
                if (chain) begin
                    start = 1'b1;
                    len = 8'(nextLen);
                end
                break;
            end
            if (in_ready) begin
                rdy++;
                if (idx < n) begin
                    if (stallLeft > 0) begin
                        stallLeft--;
                        if (mac_a != 16'h0 || mac_b != 16'h0) stallBad++;
                    end else begin
                        in_valid = 1'b1;
                        in_a = jobA[idx];
                        in_b = jobB[idx];
                        idx++;
                        stallLeft = (idx < 8) ? stallBefore[idx] : 0;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, busy, done, mac_clr} !== 4'b0001 || result !== 16'h0 ||
            mac_a !== 16'h0 || mac_b !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: rdy/busy/done/clr=%b result=%h a=%h b=%h, want 0001 0000 0000 0000",
                     {in_ready, busy, done, mac_clr}, result, mac_a, mac_b);
        end
        rst = 1'b1;
        #1;
        total++;
        if (mac_clr !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_clr: mac_clr=%b want 0", mac_clr);
        end
    endtask

    task automatic test_basic();
        int cyc, rdy, sb;
        logic [15:0] res;
        clear_job();
        jobA[0] = 16'd2;  jobB[0] = 16'd3;
        jobA[1] = 16'd4;  jobB[1] = 16'd5;
        jobA[2] = 16'hFFFF; jobB[2] = 16'd7;
        do_job(3, 1'b0, 1'b0, 0, cyc, rdy, sb, res);
        total++;
        if (res !== 16'h0013) begin
            bad++;
            $display("FAIL basic_result: got %h want 0013", res);
        end
        total++;
        if (cyc !== 6) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 6", cyc);
        end
        total++;
        if (rdy !== 3) begin
            bad++;
            $display("FAIL basic_ready_cycles: got %0d want 3", rdy);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h0013) begin
            bad++;
            $display("FAIL basic_after: done=%b busy=%b result=%h want 0 0 0013", done, busy, result);
        end
    endtask

    task automatic test_stall();
        int cyc, rdy, sb;
        logic [15:0] res;
        clear_job();
        jobA[0] = 16'd2;  jobB[0] = 16'd3;
        jobA[1] = 16'd4;  jobB[1] = 16'd5;
        jobA[2] = 16'hFFFF; jobB[2] = 16'd7;
        stallBefore[1] = 2;
        do_job(3, 1'b0, 1'b0, 0, cyc, rdy, sb, res);
        total++;
        if (res !== 16'h0013) begin
            bad++;
            $display("FAIL stall_result: got %h want 0013", res);
        end
        total++;
        if (cyc !== 8) begin
            bad++;
            $display("FAIL stall_latency: got %0d want 8", cyc);
        end
        total++;
        if (sb !== 0 || rdy !== 5) begin
            bad++;
            $display("FAIL stall_operands: nonzero=%0d ready=%0d want 0 5", sb, rdy);
        end
    endtask

    task automatic test_wrap();
        int cyc, rdy, sb;
        logic [15:0] res;
        clear_job();
        jobA[0] = 16'd300; jobB[0] = 16'd300;
        jobA[1] = 16'd256; jobB[1] = 16'd256;
        do_job(2, 1'b0, 1'b0, 0, cyc, rdy, sb, res);
        total++;
        if (res !== 16'h5F90) begin
            bad++;
            $display("FAIL wrap_result: got %h want 5f90", res);
        end
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start = 1'b1;
        len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || mac_clr !== 1'b0 || result !== 16'h0000) begin
            bad++;
            $display("FAIL len0_done: done=%b busy=%b clr=%b result=%h want 1 0 0 0000",
                     done, busy, mac_clr, result);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_after: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, rdy, sb;
        logic [15:0] res;
        clear_job();
        jobA[0] = 16'd7; jobB[0] = 16'd7;
        do_job(1, 1'b0, 1'b1, 1, cyc, rdy, sb, res);
        total++;
        if (res !== 16'h0031) begin
            bad++;
            $display("FAIL b2b_first: got %h want 0031", res);
        end
        jobA[0] = 16'd1; jobB[0] = 16'd1;
        do_job(1, 1'b1, 1'b0, 0, cyc, rdy, sb, res);
        total++;
        if (res !== 16'h0001 || cyc !== 4) begin
            bad++;
            $display("FAIL b2b_second: result=%h cycles=%0d want 0001 4", res, cyc);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, rdy, sb;
        logic [15:0] res;
        @(negedge clk);
        start = 1'b1;
        len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 16'd9;
        in_b = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, done, mac_clr} !== 4'b0001 || result !== 16'h0 ||
            mac_a !== 16'h0 || mac_b !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid: rdy/busy/done/clr=%b result=%h a=%h b=%h want 0001 0000 0000 0000",
                     {in_ready, busy, done, mac_clr}, result, mac_a, mac_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_job();
        jobA[0] = 16'hFFFD; jobB[0] = 16'd5;
        do_job(1, 1'b0, 1'b0, 0, cyc, rdy, sb, res);
        total++;
        if (res !== 16'hFFF1) begin
            bad++;
            $display("FAIL reset_mid_rerun: got %h want fff1", res);
        end
    endtask

    task automatic test_idle_valid();
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 16'd11;
        in_b = 16'd13;
        #1;
        total++;
        if (in_ready !== 1'b0 || mac_a !== 16'h0 || mac_b !== 16'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid: ready=%b a=%h b=%h busy=%b want 0 0000 0000 0",
                     in_ready, mac_a, mac_b, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len_zero();
        test_back_to_back();
        test_reset_mid();
        test_idle_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Initiator/driver for the 16-bit MAC datapath: sequences one dot-product job of N operand pairs into the MAC, then reads back the accumulated result.
- Sits between an upstream operand stream (valid/ready) and the MAC's a/b/rst/op pins.
- Clears the accumulator, feeds exactly N accepted pairs, waits one cycle for the MAC register to settle, then captures op as result with a done pulse.

Parameters:
- LEN_W, 8, width of job length; max job = 2^LEN_W-1 pairs.
- DW, 16, operand/result width; must match the MAC (16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  block accepts pair this cycle.
- in_a  in  DW  operand A (two's complement).
- in_b  in  DW  operand B (two's complement).
- mac_a  out  DW  to MAC a.
- mac_b  out  DW  to MAC b.
- mac_clr  out  1  to MAC reset (active-high clear).
- mac_op  in  DW  from MAC op (registered accumulator).
- busy  out  1  high in CLEAR/FEED/DRAIN.
- done  out  1  one-cycle pulse: result valid.
- result  out  DW  captured accumulator; holds until next capture.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, result=0, done=0; in_ready=0, busy=0, mac_a=mac_b=0, and mac_clr=1 (combinational from ~rst) so the MAC clears with us.
- States: IDLE, CLEAR, FEED, DRAIN.
- IDLE:
  - start=1 & len!=0: count<=len, go CLEAR.
  - start=1 & len=0: result<=0, done<=1 next cycle, stay IDLE.
  - start outside IDLE: ignored.
- CLEAR: exactly one cycle; mac_clr=1, mac_a=mac_b=0; next state FEED.
- FEED:
  - in_ready=1; accept = in_valid & in_ready.
  - mac_a/mac_b = accept ? in_a/in_b : 0 (combinational passthrough). A zero product adds 0, so stalls leave the accumulator unchanged.
  - On accept: count<=count-1. Accept with count=1: go DRAIN.
- DRAIN: one cycle, in_ready=0, operands 0. At the DRAIN edge, result<=mac_op, done<=1, state->IDLE.
- Latency:
  - Final accept at edge E, so the MAC register holds the final sum after E.
  - result/done valid in the cycle after E+1.
  - done deasserts at E+2.
  - Job time = N + stalls + 3 cycles from start edge to done.
- Arithmetic: MAC computes 16-bit signed products and accumulates modulo 2^16. The block passes mac_op unaltered, with no saturation or overflow flag.
- mac_clr=0 outside CLEAR and reset.
- done and start in the same cycle (IDLE): new job starts; done pulse is unaffected.
- in_valid held high with no job: not accepted (in_ready=0), no MAC activity.
- Reset mid-job: immediate abort to IDLE, no done, result=0, MAC cleared; the partial sum is discarded.
- Back-to-back jobs: the CLEAR state guarantees a fresh accumulator per job; result of the prior job is held until the new DRAIN.

Test Plan:
- len=3, pairs (2,3),(4,5),(-1,7), in_valid always 1 -> in_ready high 3 cycles, done 1 cycle, result=0x0013 (19), busy low after.
- Same job with in_valid low 2 cycles between pairs 1 and 2 -> result still 0x0013, done 2 cycles later than the previous case, mac_a/mac_b=0 during stalls.
- len=2, pairs (300,300),(256,256) -> wrap: 90000+65536 mod 65536 -> result=0x5F90.
- start with len=0 -> no CLEAR, busy stays 0, done pulses next cycle, result=0x0000.
- Reset asserted mid-FEED after 1 of 4 pairs -> outputs zero immediately, mac_clr=1; after release, job len=1 with (-3,5) -> result=0xFFF1.
- Two back-to-back jobs ((7,7) then (1,1)) with start asserted in the done cycle -> results 0x0031 then 0x0001; no carry-over from the first job.
